// File: rtl/read_bram.sv
// read_bram: streams BRAM[offset +: length] onto a write sink through a credit-guarded skid FIFO.
// Define READ_BRAM_LOOP_EN to add loop_count (region replayed loop_count+1 times per op_start).
module read_bram #(
  parameter int WIDTH        = 512,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int SKID_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
`ifdef READ_BRAM_LOOP_EN
  input  logic [15:0]           loop_count,
`endif
  output logic                  op_done,
  output logic                  memory_access_re,
  output logic [ADDR_WIDTH-1:0] memory_access_raddr,
  input  logic [WIDTH-1:0]      memory_access_rdata,
  output logic                  out_read_we,
  output logic [WIDTH-1:0]      out_read_wdata,
  input  logic                  out_read_almostfull
);
  localparam int PW = SKID_DEPTH > 1 ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [CW:0] DEPTH = (CW+1)'(SKID_DEPTH);

  if (SKID_DEPTH < READ_LATENCY + 3) begin : g_depth_chk
    $error("read_bram: SKID_DEPTH must be >= READ_LATENCY+3");
  end
  if (READ_LATENCY < 1) begin : g_lat_chk
    $error("read_bram: READ_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             offset_q, offset_d, length_q, length_d, issued_q, issued_d;
  logic                    re_q, re_d, we_q, we_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [READ_LATENCY-1:0] valid_q, valid_d;
  logic [CW-1:0]           inflight_q, inflight_d, count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [WIDTH-1:0]        skid_q [SKID_DEPTH];
  logic                    start, issue, push, pop, last, wrap, drain_done;
`ifdef READ_BRAM_LOOP_EN
  logic [15:0]             loops_q, loops_d, pass_q, pass_d;
`endif

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(SKID_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // credits = SKID_DEPTH - skid_count - inflight; issue only while a credit remains
  always_comb begin
    start      = state_q == IDLE && op_start;
    push       = valid_q[READ_LATENCY-1];
    pop        = count_q != '0 && !out_read_almostfull;
    issue      = state_q == READ && issued_q < length_q &&
                 ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH;
    last       = issue && issued_q + 16'd1 == length_q;
`ifdef READ_BRAM_LOOP_EN
    wrap       = last && pass_q != loops_q;
`else
    wrap       = 1'b0;
`endif
    drain_done = state_q == DRAIN && inflight_q == '0 && count_q == '0;
  end

  always_comb begin
    state_d = (start && configreg[31:16] != '0) ? READ :
              (last && !wrap)                   ? DRAIN :
              drain_done                        ? IDLE : state_q;
  end

  always_comb begin
    offset_d   = start ? configreg[15:0] : offset_q;
    length_d   = start ? configreg[31:16] : length_q;
    issued_d   = (start || wrap) ? '0 : issue ? issued_q + 16'd1 : issued_q;
`ifdef READ_BRAM_LOOP_EN
    loops_d    = start ? loop_count : loops_q;
    pass_d     = start ? '0 : wrap ? pass_q + 16'd1 : pass_q;
`endif
    re_d       = issue;
    raddr_d    = issue ? ADDR_WIDTH'(offset_q + issued_q) : raddr_q;
    valid_d    = READ_LATENCY'({valid_q, re_q});
    inflight_d = inflight_q + CW'(issue) - CW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? inc(rd_ptr_q) : rd_ptr_q;
    we_d       = pop;
    wdata_d    = pop ? skid_q[rd_ptr_q] : wdata_q;
    done_d     = (start && configreg[31:16] == '0) || drain_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      re_q       <= re_d;
      we_q       <= we_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    offset_q <= offset_d;
    length_q <= length_d;
    raddr_q  <= raddr_d;
    wdata_q  <= wdata_d;
`ifdef READ_BRAM_LOOP_EN
    loops_q  <= loops_d;
    pass_q   <= pass_d;
`endif
    if (push) skid_q[wr_ptr_q] <= memory_access_rdata;
  end

  assign op_done             = done_q;
  assign memory_access_re    = re_q;
  assign memory_access_raddr = raddr_q;
  assign out_read_we         = we_q;
  assign out_read_wdata      = wdata_q;
endmodule

// File: tb/tb_read_bram.sv
// tb_read_bram: randomized self-checking bench for read_bram against an address/word-list reference model.
module tb_read_bram;
  localparam int WIDTH = 512;
  localparam int AW    = 16;
  localparam int RL    = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset, op_start, op_done, re, we, almostfull;
  logic [31:0] configreg;
  logic [AW-1:0] raddr;
  logic [WIDTH-1:0] rdata, wdata;
`ifdef READ_BRAM_LOOP_EN
  logic [15:0] loop_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] seed = 32'h1;

  read_bram #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .SKID_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .configreg(configreg),
`ifdef READ_BRAM_LOOP_EN
    .loop_count(loop_count),
`endif
    .op_done(op_done), .memory_access_re(re), .memory_access_raddr(raddr),
    .memory_access_rdata(rdata), .out_read_we(we), .out_read_wdata(wdata),
    .out_read_almostfull(almostfull)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] mem_word(input logic [15:0] a);
    return {(WIDTH/32){seed ^ {a, ~a}}};
  endfunction

  // BRAM model: address registered, data one cycle later (latency 2)
  logic [AW-1:0] a_pipe;
  always @(posedge clk) begin
    a_pipe <= raddr;
    rdata  <= mem_word(a_pipe);
  end

  logic [15:0]      re_addr[$];
  int               re_cyc[$];
  logic [WIDTH-1:0] we_data[$];
  int               we_cyc[$];
  int               done_cyc[$];
  always @(negedge clk) begin
    if (re) begin re_addr.push_back(raddr); re_cyc.push_back(cyc); end
    if (we) begin we_data.push_back(wdata); we_cyc.push_back(cyc); end
    if (op_done) done_cyc.push_back(cyc);
  end

  function automatic logic af_val(input int mode, input int rel);
    return mode == 0 ? 1'b0 : mode == 1 ? 1'($urandom_range(0, 1)) : (rel % 8) < 5;
  endfunction

  task automatic run_op(input logic [15:0] off, input logic [15:0] len, input logic [15:0] lp,
                        input int af_mode, input string name);
    int rb, wb, db, sc, budget, max_out, out_now;
    logic [15:0] exp_a[$];
    rb = re_addr.size(); wb = we_data.size(); db = done_cyc.size();
    if (len != 0)
`ifdef READ_BRAM_LOOP_EN
      for (int p = 0; p <= int'(lp); p++)
`else
      for (int p = 0; p <= 0; p++)
`endif
        for (int i = 0; i < int'(len); i++) exp_a.push_back(off + 16'(i));
    seed = $urandom;
    @(posedge clk); #1;
    sc = cyc;
    op_start = 1'b1; configreg = {len, off};
`ifdef READ_BRAM_LOOP_EN
    loop_count = lp;
`endif
    @(posedge clk); #1;
    op_start = 1'b0; configreg = $urandom;
    budget = 0; max_out = 0;
    while (done_cyc.size() == db && budget < 2000) begin
      almostfull = af_val(af_mode, cyc - sc);
      @(posedge clk); #1;
      out_now = (re_addr.size() - rb) - (we_data.size() - wb);
      if (out_now > max_out) max_out = out_now;
      budget++;
    end
    almostfull = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_cyc.size() - db !== 1) begin
      errors++; $display("FAIL %s done_count got %0d exp 1", name, done_cyc.size() - db);
    end
    checks++;
    if (re_addr.size() - rb !== exp_a.size()) begin
      errors++; $display("FAIL %s re_count got %0d exp %0d", name, re_addr.size() - rb, exp_a.size());
    end
    checks++;
    if (we_data.size() - wb !== exp_a.size()) begin
      errors++; $display("FAIL %s we_count got %0d exp %0d", name, we_data.size() - wb, exp_a.size());
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      if (rb + i < re_addr.size()) begin
        checks++;
        if (re_addr[rb+i] !== exp_a[i]) begin
          errors++; $display("FAIL %s raddr[%0d] got %h exp %h", name, i, re_addr[rb+i], exp_a[i]);
        end
      end
      if (wb + i < we_data.size()) begin
        checks++;
        if (we_data[wb+i] !== mem_word(exp_a[i])) begin
          errors++; $display("FAIL %s wdata[%0d] got %h exp %h", name, i, we_data[wb+i][31:0], mem_word(exp_a[i]) ~^ 512'd0);
        end
      end
    end
    if (done_cyc.size() > db) begin
      checks++;
      if (exp_a.size() == 0) begin
        if (done_cyc[db] !== sc + 1) begin
          errors++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_cyc[db] - sc, 1);
        end
      end else if (we_cyc.size() > wb && done_cyc[db] !== we_cyc[we_cyc.size()-1] + 1) begin
        errors++; $display("FAIL %s done_after_last_we got %0d exp %0d", name, done_cyc[db], we_cyc[we_cyc.size()-1] + 1);
      end
    end
    checks++;
    if (af_mode == 2 ? max_out !== DEPTH : max_out > DEPTH) begin
      errors++; $display("FAIL %s outstanding got %0d exp %s%0d", name, max_out, af_mode == 2 ? "" : "<=", DEPTH);
    end
    if (af_mode == 0 && exp_a.size() != 0 && re_cyc.size() > rb && we_cyc.size() > wb) begin
      checks++;
      if (re_cyc[rb] - sc !== 2) begin
        errors++; $display("FAIL %s first_re_cycle got %0d exp 2", name, re_cyc[rb] - sc);
      end
      checks++;
      if (we_cyc[wb] - sc !== RL + 4) begin
        errors++; $display("FAIL %s first_we_cycle got %0d exp %0d", name, we_cyc[wb] - sc, RL + 4);
      end
      checks++;
      if (we_cyc[we_cyc.size()-1] - we_cyc[wb] !== exp_a.size() - 1) begin
        errors++; $display("FAIL %s we_span got %0d exp %0d", name, we_cyc[we_cyc.size()-1] - we_cyc[wb], exp_a.size() - 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({re, we, op_done} !== 3'b000) begin
      errors++; $display("FAIL reset_hold re/we/done got %b exp 000", {re, we, op_done});
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({re, we, op_done} !== 3'b000) begin
      errors++; $display("FAIL reset_idle re/we/done got %b exp 000", {re, we, op_done});
    end
  endtask

  task automatic test_basic();
    run_op(16'h0010, 16'd4, 16'd0, 0, "basic");
  endtask

  task automatic test_zero_len();
    run_op(16'($urandom), 16'd0, 16'd3, 0, "zero_len");
  endtask

  task automatic test_wrap();
    run_op(16'hFFFE, 16'd4, 16'd0, 0, "addr_wrap");
  endtask

  task automatic test_backpressure();
    run_op(16'($urandom), 16'd32, 16'd0, 2, "backpressure");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_op(16'($urandom), 16'($urandom_range(1, 40)), 16'd0, 1, "random");
  endtask

  task automatic test_back_to_back();
    run_op(16'h0100, 16'd7, 16'd0, 0, "b2b_a");
    run_op(16'h0107, 16'd9, 16'd0, 1, "b2b_b");
  endtask

  task automatic test_reset_mid();
    int rb, wb, db, wr, budget;
    logic [15:0] off;
    rb = re_addr.size(); wb = we_data.size(); db = done_cyc.size();
    off = 16'($urandom);
    seed = $urandom;
    @(posedge clk); #1;
    op_start = 1'b1; configreg = {16'd16, off};
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    op_start = 1'b1; configreg = {16'd5, 16'h1234};
    @(posedge clk); #1;
    op_start = 1'b0;
    budget = 0;
    while (we_data.size() - wb < 3 && budget < 100) begin
      @(posedge clk); #1; budget++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    wr = we_data.size();
    checks++;
    if ({re, we, op_done} !== 3'b000) begin
      errors++; $display("FAIL mid_reset re/we/done got %b exp 000", {re, we, op_done});
    end
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done_cyc.size() - db !== 0) begin
      errors++; $display("FAIL mid_reset done_count got %0d exp 0", done_cyc.size() - db);
    end
    checks++;
    if (we_data.size() !== wr || we_data.size() - wb < 3) begin
      errors++; $display("FAIL mid_reset words got %0d after_reset %0d exp >=3 and 0 after", we_data.size() - wb, we_data.size() - wr);
    end
    for (int i = 0; i < re_addr.size() - rb; i++) begin
      checks++;
      if (i >= 16 || re_addr[rb+i] !== off + 16'(i)) begin
        errors++; $display("FAIL mid_reset raddr[%0d] got %h exp %h", i, re_addr[rb+i], off + 16'(i));
      end
    end
    for (int i = 0; i < we_data.size() - wb; i++) begin
      checks++;
      if (we_data[wb+i] !== mem_word(off + 16'(i))) begin
        errors++; $display("FAIL mid_reset wdata[%0d] got %h exp %h", i, we_data[wb+i][31:0], mem_word(off + 16'(i)) ~^ 512'd0);
      end
    end
    run_op(16'h0040, 16'd5, 16'd0, 0, "after_reset");
  endtask

`ifdef READ_BRAM_LOOP_EN
  task automatic test_loop();
    run_op(16'h0020, 16'd3, 16'd1, 0, "loop");
    run_op(16'h0300, 16'd0, 16'd4, 0, "loop_zero_len");
    run_op(16'($urandom), 16'($urandom_range(1, 12)), 16'($urandom_range(0, 3)), 1, "loop_random");
  endtask
`endif

  initial begin
    reset = 1'b1; op_start = 1'b0; configreg = '0; almostfull = 1'b0;
`ifdef READ_BRAM_LOOP_EN
    loop_count = '0;
`endif
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef READ_BRAM_LOOP_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
